// File: rtl/matrix_alu.sv
// matrix_alu: 5x5 signed 8-bit matrix arithmetic unit with a permutation-sum determinant FSM
module matrix_alu (
    input  logic         clk,
    input  logic         rst,
    input  logic [199:0] A_flat,
    input  logic [199:0] B_flat,
    input  logic [7:0]   f,
    input  logic [2:0]   opcode,
    output logic [199:0] C_flat,
    output logic         overflow_flag,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state;
    logic [2:0] last_opcode, mv, mi, j;
    logic [2:0] p [5];
    logic [2:0] np [5];
    logic [199:0] a_q, b_q, res;
    logic signed [7:0] f_q;
    logic [4:0] dir, ndir;
    logic [6:0] cnt;
    logic pend, sgn, ok, ovf;
    logic signed [19:0] ex [25];
    logic signed [39:0] prod;
    logic signed [31:0] acc;

    function automatic logic signed [7:0] el(input logic [199:0] m, input int i);
        return m[i*8 +: 8];
    endfunction

    function automatic logic signed [19:0] dot(input logic [199:0] a, input logic [199:0] b, input int r, input int c);
        logic signed [19:0] s;
        s = '0;
        for (int k = 0; k < 5; k++) s = s + 20'(el(a, r*5 + k)) * 20'(el(b, k*5 + c));
        return s;
    endfunction

    always_comb begin
        res = '0;
        ovf = 1'b0;
        for (int e = 0; e < 25; e++) begin
            ex[e] = last_opcode == 3'd1 ? 20'(el(a_q, e)) + 20'(el(b_q, e))
                  : last_opcode == 3'd2 ? 20'(el(a_q, e)) - 20'(el(b_q, e))
                  : last_opcode == 3'd3 ? dot(a_q, b_q, e / 5, e % 5)
                  : last_opcode == 3'd4 ? -20'(el(a_q, e))
                  : last_opcode == 3'd5 ? 20'(el(a_q, (e % 5)*5 + e / 5))
                  : last_opcode == 3'd6 ? 20'(f_q) * 20'(el(a_q, e))
                  : 20'sd0;
            res[e*8 +: 8] = ex[e][7:0];
            ovf = ovf | (ex[e] > 20'sd127) | (ex[e] < -20'sd128);
        end
    end

    // Steinhaus-Johnson-Trotter step: move the largest mobile value one place along its direction
    always_comb begin
        ok = 1'b0;
        mv = '0;
        mi = '0;
        for (int i = 0; i < 5; i++)
            if ((dir[p[i]] ? (i < 4 && p[i < 4 ? i + 1 : i] < p[i]) : (i > 0 && p[i > 0 ? i - 1 : i] < p[i]))
                && (!ok || p[i] > mv)) begin
                ok = 1'b1;
                mv = p[i];
                mi = 3'(i);
            end
        j = dir[mv] ? mi + 3'd1 : mi - 3'd1;
        np = p;
        if (ok) begin
            np[mi] = p[j];
            np[j] = mv;
        end
        for (int v = 0; v < 5; v++) ndir[v] = 3'(v) > mv ? ~dir[v] : dir[v];
        prod = 40'sd1;
        for (int r = 0; r < 5; r++) prod = prod * 40'(el(a_q, r*5 + int'(p[r])));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last_opcode <= '0;
            a_q <= '0;
            b_q <= '0;
            f_q <= '0;
            C_flat <= '0;
            overflow_flag <= 1'b0;
            done <= 1'b0;
            pend <= 1'b0;
            acc <= '0;
            cnt <= '0;
            sgn <= 1'b0;
            dir <= '0;
            p <= '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        end else if (opcode != last_opcode) begin
            last_opcode <= opcode;
            a_q <= A_flat;
            b_q <= B_flat;
            f_q <= f;
            done <= 1'b0;
            pend <= 1'b1;
            state <= IDLE;
        end else if (pend) begin
            pend <= 1'b0;
            if (last_opcode == 3'd7) begin
                state <= RUN;
                acc <= '0;
                cnt <= '0;
                sgn <= 1'b0;
                dir <= '0;
                p <= '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
            end else begin
                C_flat <= res;
                overflow_flag <= ovf;
                done <= 1'b1;
            end
        end else if (state == RUN) begin
            acc <= acc + (sgn ? -prod[31:0] : prod[31:0]);
            sgn <= ~sgn;
            p <= np;
            dir <= ndir;
            cnt <= cnt + 7'd1;
            if (cnt == 7'd119) state <= FIN;
        end else if (state == FIN) begin
            C_flat <= {192'd0, acc[7:0]};
            overflow_flag <= (acc > 32'sd127) || (acc < -32'sd128);
            done <= 1'b1;
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_matrix_alu.sv
// tb_matrix_alu: directed vectors with hand-computed results for matrix_alu
module tb_matrix_alu;
    logic clk = 1'b0, rst = 1'b1;
    logic [199:0] A = '0, B = '0, C_flat, e;
    logic [7:0] f = '0;
    logic [2:0] opcode = '0;
    logic overflow_flag, done;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    matrix_alu dut (
        .clk(clk), .rst(rst), .A_flat(A), .B_flat(B), .f(f), .opcode(opcode),
        .C_flat(C_flat), .overflow_flag(overflow_flag), .done(done)
    );

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] m;
        for (int i = 0; i < 25; i++) m[i*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] diag(input logic [39:0] d);
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < 5; r++) m[(r*6)*8 +: 8] = d[r*8 +: 8];
        return m;
    endfunction

    task automatic run(input logic [2:0] op, output int lat);
        @(negedge clk);
        opcode = op;
        lat = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (n > 0 && done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic op_check(input string tag, input logic [2:0] op, input logic [199:0] exp_c, input logic exp_ovf, input int exp_lat);
        int lat;
        run(op, lat);
        check({tag, "_lat"}, 200'(lat), 200'(exp_lat));
        check({tag, "_c"}, C_flat, exp_c);
        check({tag, "_ovf"}, 200'(overflow_flag), 200'(exp_ovf));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_c", C_flat, '0);
        check("rst_ovf", 200'(overflow_flag), '0);
        check("rst_done", 200'(done), '0);
        @(negedge clk);
        rst = 1'b0;

        A = fill(8'd14);
        f = 8'd10;
        op_check("scal", 3'd6, fill(8'h8C), 1'b1, 1);

        B = '0;
        B[23:0] = 24'h030201;
        e = fill(8'd14);
        e[23:0] = 24'h11100F;
        op_check("add", 3'd1, e, 1'b0, 1);
        e[23:0] = 24'h0B0C0D;
        op_check("sub", 3'd2, e, 1'b0, 1);

        A = fill(8'd5);
        A[7:0] = 8'h80;
        e = fill(8'hFB);
        e[7:0] = 8'h80;
        op_check("neg", 3'd4, e, 1'b1, 1);

        for (int i = 0; i < 25; i++) begin
            A[i*8 +: 8] = 8'(i);
            e[i*8 +: 8] = 8'((i % 5)*5 + i / 5);
        end
        op_check("trn", 3'd5, e, 1'b0, 1);

        A = diag(40'h0101010101);
        for (int i = 0; i < 25; i++) B[i*8 +: 8] = 8'(i*3 - 37);
        op_check("mul_id", 3'd3, B, 1'b0, 1);
        op_check("nop", 3'd0, '0, 1'b0, 1);
        A = fill(8'd14);
        B = fill(8'd1);
        op_check("mul70", 3'd3, fill(8'd70), 1'b0, 1);
        op_check("nop2", 3'd0, '0, 1'b0, 1);
        B = fill(8'd2);
        op_check("mul140", 3'd3, fill(8'h8C), 1'b1, 1);

        op_check("nop3", 3'd0, '0, 1'b0, 1);
        A = diag(40'h0504030201);
        op_check("det120", 3'd7, {192'd0, 8'd120}, 1'b0, 122);
        op_check("nop4", 3'd0, '0, 1'b0, 1);
        A = fill(8'd14);
        op_check("det0", 3'd7, '0, 1'b0, 122);
        op_check("nop5", 3'd0, '0, 1'b0, 1);
        A = diag(40'h0202020202);
        op_check("det32", 3'd7, {192'd0, 8'd32}, 1'b0, 122);
        op_check("nop6", 3'd0, '0, 1'b0, 1);
        A = diag(40'h0303030303);
        op_check("det243", 3'd7, {192'd0, 8'hF3}, 1'b1, 122);

        A = fill(8'd14);
        f = 8'd10;
        op_check("scal2", 3'd6, fill(8'h8C), 1'b1, 1);
        A = diag(40'h0303030303);
        @(negedge clk);
        opcode = 3'd7;
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_c", C_flat, '0);
        check("mid_rst_ovf", 200'(overflow_flag), '0);
        check("mid_rst_done", 200'(done), '0);
        A = diag(40'h0504030201);
        @(posedge clk);
        #1;
        rst = 1'b0;
        op_check("det_after_rst", 3'd7, {192'd0, 8'd120}, 1'b0, 122);

        op_check("nop7", 3'd0, '0, 1'b0, 1);
        A = diag(40'h0303030303);
        @(negedge clk);
        opcode = 3'd7;
        repeat (30) @(posedge clk);
        A = fill(8'd14);
        B = '0;
        op_check("abort", 3'd1, fill(8'd14), 1'b0, 1);
        repeat (130) @(posedge clk);
        #1;
        check("no_stale_c", C_flat, fill(8'd14));
        check("no_stale_ovf", 200'(overflow_flag), '0);

        A = fill(8'd99);
        B = fill(8'd3);
        repeat (5) @(posedge clk);
        #1;
        check("hold_c", C_flat, fill(8'd14));
        check("hold_done", 200'(done), 200'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matrix_alu.md
Name: matrix_alu

Overview:
- Clocked arithmetic unit for the matrix coprocessor. Operates on 5x5 matrices of signed 8-bit elements: add, subtract, multiply, negate, transpose, scalar product and determinant.
- Operands arrive as flattened 200-bit buses. Result returns on a 200-bit bus with an overflow flag and a done flag.
- Sits between the coprocessor instruction decoder and the matrix register file.

Parameters:
- none; matrix size fixed at 5x5, element width 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- A_flat  input  200  matrix A. Element (r,c) at bits [(r*5+c)*8 +: 8], signed two's complement.
- B_flat  input  200  matrix B, same packing as A_flat.
- f  input  8  signed scalar for scalar product.
- opcode  input  3  operation select.
- C_flat  output  200  result matrix, same packing; registered.
- overflow_flag  output  1  any result element out of signed 8-bit range; registered.
- done  output  1  result valid; registered.

Behaviour:
- Clocking and reset: one clock (clk); asynchronous active-high reset (rst).
- Reset values: C_flat=0, overflow_flag=0, done=0. Internal last_opcode=000. Determinant FSM returns to IDLE.

Launch rules:
- An operation launches on a rising clk where opcode != last_opcode.
- At launch: last_opcode<=opcode, A_flat, B_flat and f are captured into internal registers, done<=0.
- Re-issuing the same operation requires changing opcode first.
- A launch while a determinant is running aborts it and starts the new operation.

Opcodes:
- 000 = NOP: C=0, overflow=0.
- 001 = C=A+B.
- 010 = C=A-B.
- 011 = C=A×B, matrix product. Exact 5-term dot products, then truncated.
- 100 = C=-A.
- 101 = C=transpose(A), i.e. C(r,c)=A(c,r). Overflow always 0.
- 110 = C=f·A.
- 111 = determinant of A. Exact value in a signed 32-bit accumulator; C element (0,0) = low 8 bits; all other elements 0.

Arithmetic rules:
- Every element is computed at full precision, then truncated to 8 bits (wrap, no saturation).
- overflow_flag = OR over all elements of (exact value outside -128..127). Examples: -(-128) overflows; 127+1 overflows.

Latency:
- Opcodes 000–110: result, overflow and done=1 registered on the clock edge after launch, i.e. 1 cycle.

Determinant FSM (IDLE -> RUN -> FIN):
- RUN visits all 120 permutations p of {0..4}, one per cycle, in Steinhaus-Johnson-Trotter order. Sign starts +1 and flips on each adjacent swap.
- Each cycle the accumulator adds sign·A(0,p0)·A(1,p1)·A(2,p2)·A(3,p3)·A(4,p4).
- FIN writes C, sets overflow (determinant outside -128..127) and sets done=1, then returns to IDLE.
- Total latency 122 cycles from launch to done=1.

Output holding:
- done stays 1, and C/overflow hold, until the next launch or reset.
- Input changes without an opcode change are ignored.
- Reset mid-determinant: outputs clear immediately and the FSM goes to IDLE. After reset release, a nonzero opcode launches on the first clock.

Test Plan:
- Opcode 110, A all 14, f=10 -> every C element = -116 (0x8C), overflow=1, done=1 one cycle after launch.
- Opcode 001, A all 14, B elements (0,0)=1, (0,1)=2, (0,2)=3, rest 0 -> C(0,0)=15, C(0,1)=16, C(0,2)=17, rest 14, overflow=0. Then opcode 010 -> C(0,0)=13, C(0,1)=12, C(0,2)=11, rest 14.
- Opcode 100 with A(0,0)=-128, rest 5 -> C(0,0)=-128, rest -5, overflow=1. Then opcode 101 with A(r,c)=r*5+c -> C(r,c)=c*5+r, overflow=0.
- Opcode 011, A=identity, B arbitrary -> C=B, overflow=0. Then A all 14, B all 1 -> each C=70, overflow=0. Then A all 14, B all 2 -> each C=140→-116, overflow=1.
- Opcode 111: diag(1,2,3,4,5) -> C(0,0)=120, others 0, done after 122 cycles. All-14 A -> 0. diag(2,2,2,2,2) -> 32. diag(3,3,3,3,3) -> 243→-13, overflow=1.
- rst asserted mid-determinant -> outputs 0 immediately. Opcode change mid-determinant -> new operation's result, no stale determinant. Holding opcode constant while changing A -> C unchanged.
